// File: rtl/cal_seq.sv
// Four-channel ADC calibration sequencer: offset add, gain multiply, round and saturate.
// One multiplier is shared across channels; coefficients are double-banked so writes never disturb a run.
module cal_seq #(
    parameter int W         = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] in0,
    input  logic signed [W-1:0] in1,
    input  logic signed [W-1:0] in2,
    input  logic signed [W-1:0] in3,
    input  logic                cal_we,
    input  logic [2:0]          cal_addr,
    input  logic signed [W-1:0] cal_wdata,
    output logic signed [W-1:0] out0,
    output logic signed [W-1:0] out1,
    output logic signed [W-1:0] out2,
    output logic signed [W-1:0] out3,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int PW = 2*W + 1;   // full-precision product
    localparam int RW = PW + 1;    // headroom for the rounding add

    localparam logic signed [W-1:0]  GAIN_ONE = W'(1 << GAIN_FRAC);
    localparam logic signed [RW-1:0] HALF     = RW'(1) << (GAIN_FRAC - 1);
    localparam logic signed [RW-1:0] SMAX     = RW'((1 << (W-1)) - 1);
    localparam logic signed [RW-1:0] SMIN     = ~SMAX;

    typedef enum logic [2:0] {S_IDLE, S_SUM, S_MUL, S_SAT, S_DONE} state_t;

    state_t r_state, w_next;

    logic                r_sc_q;
    logic [1:0]          r_ch;
    logic signed [W:0]   r_sum;
    logic signed [PW-1:0] r_prod;
    logic signed [W-1:0] r_snap     [4];
    logic signed [W-1:0] r_result   [3];
    logic signed [W-1:0] r_off_stg  [4];
    logic signed [W-1:0] r_gain_stg [4];
    logic signed [W-1:0] r_off_act  [4];
    logic signed [W-1:0] r_gain_act [4];

    logic                w_trig;
    logic signed [W-1:0] w_in [4];
    logic signed [RW-1:0] w_round;
    logic signed [RW-1:0] w_shift;
    logic signed [W-1:0] w_sat;

    assign w_trig = ~sample_clk & r_sc_q;
    assign busy   = (r_state != S_IDLE);

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;

    assign w_round = {r_prod[PW-1], r_prod} + HALF;
    assign w_shift = w_round >>> GAIN_FRAC;

    always_comb begin
        w_sat = w_shift[W-1:0];
        if (w_shift > SMAX)
            w_sat = {1'b0, {(W-1){1'b1}}};
        else if (w_shift < SMIN)
            w_sat = {1'b1, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_trig) w_next = S_SUM;
            S_SUM:  w_next = S_MUL;
            S_MUL:  w_next = S_SAT;
            S_SAT:  w_next = (r_ch == 2'd3) ? S_DONE : S_SUM;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc_q    <= 1'b0;
            r_ch      <= 2'd0;
            r_sum     <= '0;
            r_prod    <= '0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_snap[i]     <= '0;
                r_off_stg[i]  <= '0;
                r_off_act[i]  <= '0;
                r_gain_stg[i] <= GAIN_ONE;
                r_gain_act[i] <= GAIN_ONE;
            end
            for (int i = 0; i < 3; i++) r_result[i] <= '0;
        end else begin
            r_sc_q    <= sample_clk;
            out_valid <= 1'b0;

            if (cal_we) begin
                if (!cal_addr[2]) r_off_stg[cal_addr[1:0]]  <= cal_wdata;
                else              r_gain_stg[cal_addr[1:0]] <= cal_wdata;
            end

            if (w_trig && r_state != S_IDLE) overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_ch <= 2'd0;
                        for (int i = 0; i < 4; i++) begin
                            r_snap[i]     <= w_in[i];
                            r_off_act[i]  <= r_off_stg[i];
                            r_gain_act[i] <= r_gain_stg[i];
                        end
                    end
                end
                S_SUM: r_sum <= {r_snap[r_ch][W-1], r_snap[r_ch]}
                              + {r_off_act[r_ch][W-1], r_off_act[r_ch]};
                S_MUL: r_prod <= r_sum * r_gain_act[r_ch];
                S_SAT: begin
                    // Channel 3 goes straight to the output so all four update with out_valid.
                    if (r_ch == 2'd3) begin
                        out0      <= r_result[0];
                        out1      <= r_result[1];
                        out2      <= r_result[2];
                        out3      <= w_sat;
                        out_valid <= 1'b1;
                    end else begin
                        r_result[r_ch] <= w_sat;
                        r_ch           <= r_ch + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cal_seq.md
CAL_SEQ -- requirements
Module: cal_seq

Interface
REQ-001 SHALL have parameter W, default 16: sample, offset and gain width, bits.
REQ-002 SHALL have parameter GAIN_FRAC, default 14: fractional bits of gain; 1<<GAIN_FRAC is unity.
REQ-003 SHALL have port clk  input  1  system clock, 24MHz, same clock as codec driver.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sample_clk  input  1  codec frame clock; raw samples valid from its falling edge.
REQ-006 SHALL have ports in0..in3  input  W signed  raw ADC samples from codec driver.
REQ-007 SHALL have port cal_we  input  1  coefficient write strobe.
REQ-008 SHALL have port cal_addr  input  3  addresses 0-3 offset ch0-3; addresses 4-7 gain ch0-3.
REQ-009 SHALL have port cal_wdata  input  W signed  coefficient value.
REQ-010 SHALL have ports out0..out3  output  W signed  calibrated samples, registered.
REQ-011 SHALL have port out_valid  output  1  one-cycle strobe when out0..out3 update.
REQ-012 SHALL have port busy  output  1  high while the state machine is not IDLE.
REQ-013 SHALL have port overrun  output  1  sticky; a trigger arrived while busy.

Function
REQ-014 SHALL register sample_clk into sc_q each cycle; trigger = sample_clk==0 && sc_q==1.
REQ-015 Coefficients SHALL be double-banked: cal_we writes the staging bank on the same clock edge, in any state.
REQ-016 On trigger in IDLE, same edge: latch in0..in3 into snapshot, copy staging bank to active bank, ch<=0, go SUM.
REQ-017 SUM SHALL compute sum = snap[ch] + offset[ch] at W+1 bits, sign-extended, no overflow; go MUL.
REQ-018 MUL SHALL compute prod = sum * gain[ch], signed, 2W+1 bits, full precision; go SAT.
REQ-019 SAT SHALL compute (prod + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC, i.e. round half up.
REQ-020 SAT SHALL then clamp to [-2^(W-1), 2^(W-1)-1] and store in result[ch].
REQ-021 From SAT: if ch<3, ch<=ch+1 and go SUM; if ch==3, go DONE.
REQ-022 DONE SHALL load out0..out3 from result simultaneously, pulse out_valid for exactly one cycle, go IDLE.
REQ-023 Latency SHALL be 13 cycles: out_valid is high in cycle T+13, where T is the trigger edge.
REQ-024 Only one multiplier SHALL exist; it is shared across all channels.
REQ-025 Trigger while busy SHALL be ignored: no snapshot, no bank copy, overrun<=1; the run in progress completes normally.
REQ-026 Trigger in the DONE cycle SHALL count as busy (REQ-025).
REQ-027 out0..out3 SHALL hold their value between out_valid pulses.
REQ-028 busy SHALL be 1 from T+1 through T+13 inclusive.

Reset
REQ-029 On rst: state IDLE, ch 0, sc_q 0, out0..out3 0, result 0, snapshot 0, out_valid 0, busy 0, overrun 0.
REQ-030 On rst: both banks reset to offset 0 and gain 1<<GAIN_FRAC, i.e. 16384 at default parameters.
REQ-031 rst SHALL take priority over trigger and cal_we in the same cycle.
REQ-032 rst mid-run SHALL abort the run: no out_valid pulse, outputs 0.
REQ-033 overrun SHALL clear only on rst.

Verification
REQ-034 Default coefficients, in0=1000, in1=-1000, in2=0, in3=32767 -> out0..out3 = same values at T+13; out_valid exactly one cycle.
REQ-035 offset1=-100, gain1=8192, in1=301 -> out1=101 (rounding check); other channels pass through unchanged.
REQ-036 Saturation cases:
- gain0=-16384, in0=-32768 -> out0=32767.
- offset2=1000, in2=32767 -> out2=32767.
- offset3=-1, in3=-32768 -> out3=-32768.
REQ-037 Second falling edge of sample_clk at T+5 -> ignored; overrun=1; single out_valid at T+13 carrying the first snapshot.
REQ-038 Write gain0=8192 at T+4 (busy), in0=1000 on both frames -> first frame out0=1000; next frame out0=500.
REQ-039 rst asserted at T+6 -> no out_valid; out0..out3=0, busy=0; next trigger processes normally with default coefficients.
